store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Post-commit store buffer between the memory stage and the data bus.
- Accepts stores whose data and byte strobe are already aligned to a 64-bit doubleword. Queues them in a small FIFO and drains them one at a time over the valid/addr_ok/data_ok dbus handshake.
- Merges a new store into the youngest queued entry when both target the same doubleword.
- Raises a stall when a load hits a pending doubleword.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the memory stage.
- st_addr  in  64  store byte address; only bits [63:3] are used.
- st_data  in  64  aligned store data; byte lanes are selected by st_strobe.
- st_strobe  in  8  byte-enable mask; never zero when st_valid=1.
- st_ready  out  1  store accepted this cycle (enqueued or merged).
- ld_valid  in  1  load lookup.
- ld_addr  in  64  load address; only bits [63:3] are compared.
- ld_stall  out  1  load overlaps a pending entry; the pipeline holds the load.
- dreq_valid  out  1  bus write request.
- dreq_addr  out  64  {head.addr[63:3], 3'b000}.
- dreq_data  out  64  head data.
- dreq_strobe  out  8  head strobe. Bus size is always 8 bytes.
- dresp_addr_ok  in  1  bus accepted the address.
- dresp_data_ok  in  1  bus completed the write.
- empty  out  1  count==0; used by fence/ecall logic.
- count  out  CNT_W  number of occupied entries.

Behaviour:
- Storage:
  - Circular FIFO with head and tail pointers and a count.
  - Each entry holds addr[63:3] (61 bits), data (64 bits) and strobe (8 bits).
- Reset (asynchronous):
  - head=tail=count=0; FSM goes to REQ.
  - Outputs: dreq_valid=0, empty=1, count=0, st_ready=1, ld_stall=0.
  - Reset mid-transaction discards every entry, including one already issued.
- Merge:
  - merge_hit = st_valid && count>=2 && tail_entry.addr == st_addr[63:3].
  - tail_entry is entry (tail-1) mod DEPTH.
  - The count>=2 requirement guarantees the tail entry is never the head being drained.
  - On merge: bytes with st_strobe[i]=1 overwrite data[8i+7:8i]; strobe |= st_strobe; count and tail are unchanged.
- Enqueue:
  - st_ready = merge_hit || count<DEPTH.
  - Without merge, st_valid && st_ready writes the entry at tail; tail wraps modulo DEPTH.
- Drain FSM (two states):
  - REQ: dreq_valid = !empty.
    - If dreq_valid && addr_ok && data_ok: pop the head; stay in REQ.
    - If dreq_valid && addr_ok && !data_ok: go to WAIT_DATA.
    - Otherwise: hold.
  - WAIT_DATA: dreq_valid=0.
    - On data_ok: pop the head; go to REQ.
  - dreq_addr, dreq_data and dreq_strobe come from the head entry. They stay stable from first dreq_valid until the pop.
  - Latency: an entry enqueued at edge t into an empty buffer drives dreq_valid in the cycle after t. Back-to-back pops are possible when addr_ok and data_ok arrive together.
- Pop:
  - head advances modulo DEPTH; count decrements.
  - Simultaneous enqueue and pop leaves count unchanged.
  - Simultaneous merge and pop: the merge targets the tail, which is not the head, so both occur.
- Full:
  - count==DEPTH with no merge_hit gives st_ready=0; the store is held by the pipeline.
  - A pop in the same cycle does not raise st_ready; there is no bypass.
- Load hazard:
  - ld_stall = ld_valid && OR over occupied entries of (entry.addr == ld_addr[63:3]).
  - Combinational; includes the head while it is in flight. No data forwarding.
- Count stays in the range 0 to DEPTH; the pointers wrap cleanly past DEPTH-1.

Test Plan:
- Reset; store addr=0x1000, data=0x11, strobe=0x01 with the bus always ready (addr_ok=data_ok=1) -> cycle after enqueue: dreq_valid=1, dreq_addr=0x1000, dreq_strobe=0x01. The next cycle empty=1.
- addr_ok=0, stores to 0x0, 0x8, 0x10, 0x18 -> count=4. A fifth store to 0x20 gives st_ready=0. A store to 0x18 with strobe 0xF0 merges (st_ready=1); the tail strobe becomes the OR and count stays 4.
- Store 0x2000 strobe 0x0F, then 0x2000 strobe 0xF0 while the head is different -> a single entry with strobe 0xFF and combined data. With count==1 at the second store there is no merge, so count=2.
- Split handshake: addr_ok at cycle n, data_ok at n+3 -> dreq_valid=0 during n+1..n+3, fields stable, pop at n+3, next entry requested at n+4.
- Pending entry at 0x3008; load at 0x300C -> ld_stall=1. Load at 0x3010 -> ld_stall=0. After the drain, load at 0x300C -> ld_stall=0.
- Reset asserted while in WAIT_DATA with count=3 -> asynchronously dreq_valid=0, count=0, empty=1. Normal operation resumes after deassertion.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Post-commit store buffer between the memory stage and the data bus.
//   Stores arrive already aligned to a 64-bit doubleword. They are queued in a
//   small circular FIFO and drained one at a time over the
//   dreq_valid / dresp_addr_ok / dresp_data_ok handshake. A store to the same
//   doubleword as the youngest entry merges into it. A load that hits any
//   pending doubleword raises ld_stall.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   st_valid/st_addr/st_data/st_strobe  store request; st_ready = accepted
//   ld_valid/ld_addr, ld_stall      load hazard lookup (combinational)
//   dreq_valid/addr/data/strobe     bus write request, driven from the head
//   dresp_addr_ok, dresp_data_ok    bus address accept / write completion
//   empty, count                    occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid,
   input  logic [63:0]      st_addr,
   input  logic [63:0]      st_data,
   input  logic [7:0]       st_strobe,
   output logic             st_ready,
   input  logic             ld_valid,
   input  logic [63:0]      ld_addr,
   output logic             ld_stall,
   output logic             dreq_valid,
   output logic [63:0]      dreq_addr,
   output logic [63:0]      dreq_data,
   output logic [7:0]       dreq_strobe,
   input  logic             dresp_addr_ok,
   input  logic             dresp_data_ok,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      S_REQ,
      S_WAIT_DATA
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [60:0]      addr_q [DEPTH];
   logic [60:0]      addr_d [DEPTH];
   logic [63:0]      data_q [DEPTH];
   logic [63:0]      data_d [DEPTH];
   logic [7:0]       strb_q [DEPTH];
   logic [7:0]       strb_d [DEPTH];

   logic [PTR_W-1:0] tail_last;
   logic [PTR_W-1:0] occ_off;
   logic             merge_hit;
   logic             enq;
   logic             pop;

   // Byte-offset bits never participate in matching or in the bus address.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{st_addr[2:0], ld_addr[2:0]};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      dreq_valid = 1'b0;
      pop        = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      strb_d     = strb_q;
      ld_stall   = 1'b0;
      occ_off    = '0;

      // The youngest entry; with count>=2 it can never be the head in flight.
      tail_last = tail_q - PTR_W'(1);
      merge_hit = st_valid && (count_q >= CNT_W'(2)) &&
                  (addr_q[tail_last] == st_addr[63:3]);
      st_ready  = merge_hit || (count_q < CNT_W'(DEPTH));
      enq       = st_valid && st_ready && !merge_hit;
      empty     = (count_q == '0);

      case (state_q)
         S_REQ: begin
            dreq_valid = !empty;
            if (dreq_valid && dresp_addr_ok) begin
               if (dresp_data_ok) pop = 1'b1;
               else               state_d = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (dresp_data_ok) begin
               pop     = 1'b1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      if (enq) begin
         addr_d[tail_q] = st_addr[63:3];
         data_d[tail_q] = st_data;
         strb_d[tail_q] = st_strobe;
      end
      if (merge_hit) begin
         for (int b = 0; b < 8; b++) begin
            if (st_strobe[b]) data_d[tail_last][8*b +: 8] = st_data[8*b +: 8];
         end
         strb_d[tail_last] = strb_q[tail_last] | st_strobe;
      end

      head_d  = pop ? head_q + PTR_W'(1) : head_q;
      tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

      // An entry is occupied when its distance from head is below count.
      for (int i = 0; i < DEPTH; i++) begin
         occ_off = PTR_W'(i) - head_q;
         if (ld_valid && (CNT_W'(occ_off) < count_q) &&
             (addr_q[i] == ld_addr[63:3])) begin
            ld_stall = 1'b1;
         end
      end
   end

   assign dreq_addr   = {addr_q[head_q], 3'b000};
   assign dreq_data   = data_q[head_q];
   assign dreq_strobe = strb_q[head_q];
   assign count       = count_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_REQ;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: entry storage is deliberately not reset; validity is defined by
   // head/count alone, so stale contents are never observed.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      strb_q <= strb_d;
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             st_valid;
   logic [63:0]      st_addr;
   logic [63:0]      st_data;
   logic [7:0]       st_strobe;
   logic             st_ready;
   logic             ld_valid;
   logic [63:0]      ld_addr;
   logic             ld_stall;
   logic             dreq_valid;
   logic [63:0]      dreq_addr;
   logic [63:0]      dreq_data;
   logic [7:0]       dreq_strobe;
   logic             dresp_addr_ok;
   logic             dresp_data_ok;
   logic             empty;
   logic [CNT_W-1:0] count;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .st_valid      (st_valid),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_strobe     (st_strobe),
      .st_ready      (st_ready),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_stall      (ld_stall),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_data     (dreq_data),
      .dreq_strobe   (dreq_strobe),
      .dresp_addr_ok (dresp_addr_ok),
      .dresp_data_ok (dresp_data_ok),
      .empty         (empty),
      .count         (count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a queue of pending doublewords plus a flag meaning the
   // bus has taken the head's address and the write completion is outstanding.
   typedef struct {
      logic [60:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } entry_t;

   entry_t m_q[$];
   bit     m_busy;

   function automatic logic [63:0] lane_mask(input logic [7:0] s);
      logic [63:0] m = '0;
      for (int b = 0; b < 8; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic bit model_merge();
      return st_valid && (m_q.size() >= 2) && (m_q[m_q.size()-1].addr == st_addr[63:3]);
   endfunction

   function automatic bit model_stall();
      if (!ld_valid) return 1'b0;
      foreach (m_q[i]) if (m_q[i].addr == ld_addr[63:3]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic set_in(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic [7:0] ss, input logic lv, input logic [63:0] la,
                         input logic aok, input logic dok);
      st_valid      = sv;
      st_addr       = sa;
      st_data       = sd;
      st_strobe     = ss;
      ld_valid      = lv;
      ld_addr       = la;
      dresp_addr_ok = aok;
      dresp_data_ok = dok;
      #1;
   endtask

   task automatic idle(input logic aok, input logic dok);
      set_in(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 64'h0, aok, dok);
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      set_in(1'b1, a, d, s, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   // Compare all outputs with the model, advance the model, clock once.
   task automatic tick();
      bit     merge, ready, dv, do_pop, nbusy;
      entry_t e;
      merge = model_merge();
      ready = merge || (m_q.size() < DEPTH);
      dv    = (m_q.size() != 0) && !m_busy;
      check("dreq_valid", {63'h0, dreq_valid}, {63'h0, dv});
      check("count", 64'(count), 64'(m_q.size()));
      check("empty", {63'h0, empty}, {63'h0, m_q.size() == 0});
      check("st_ready", {63'h0, st_ready}, {63'h0, ready});
      check("ld_stall", {63'h0, ld_stall}, {63'h0, model_stall()});
      if (m_q.size() != 0) begin
         check("dreq_addr", dreq_addr, {m_q[0].addr, 3'b000});
         check("dreq_strobe", {56'h0, dreq_strobe}, {56'h0, m_q[0].strb});
         check("dreq_data", dreq_data & lane_mask(m_q[0].strb),
               m_q[0].data & lane_mask(m_q[0].strb));
      end
      if (m_busy) begin
         do_pop = dresp_data_ok;
         nbusy  = !dresp_data_ok;
      end else begin
         do_pop = dv && dresp_addr_ok && dresp_data_ok;
         nbusy  = dv && dresp_addr_ok && !dresp_data_ok;
      end
      if (merge) begin
         e = m_q[m_q.size()-1];
         e.data = (e.data & ~lane_mask(st_strobe)) | (st_data & lane_mask(st_strobe));
         e.strb = e.strb | st_strobe;
         m_q[m_q.size()-1] = e;
      end else if (st_valid && ready) begin
         e.addr = st_addr[63:3];
         e.data = st_data;
         e.strb = st_strobe;
         m_q.push_back(e);
      end
      if (do_pop) void'(m_q.pop_front());
      m_busy = nbusy;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 4 * DEPTH && (m_q.size() != 0 || m_busy); k++) begin
         idle(1'b1, 1'b1);
         tick();
      end
      idle(1'b0, 1'b0);
      check("drained", {63'h0, empty}, 64'h1);
   endtask

   initial begin
      reset = 1'b1;
      m_busy = 1'b0;
      set_in(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 64'h0, 1'b0, 1'b0);
      check("rst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
      check("rst_empty", {63'h0, empty}, 64'h1);
      check("rst_count", 64'(count), 64'h0);
      check("rst_st_ready", {63'h0, st_ready}, 64'h1);
      check("rst_ld_stall", {63'h0, ld_stall}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single store with an always-ready bus: request the cycle after enqueue.
      set_in(1'b1, 64'h1000, 64'h11, 8'h01, 1'b0, 64'h0, 1'b1, 1'b1);
      check("s1_st_ready", {63'h0, st_ready}, 64'h1);
      tick();
      idle(1'b1, 1'b1);
      check("s1_dreq_valid", {63'h0, dreq_valid}, 64'h1);
      check("s1_dreq_addr", dreq_addr, 64'h1000);
      check("s1_dreq_strobe", {56'h0, dreq_strobe}, 64'h01);
      tick();
      idle(1'b1, 1'b1);
      check("s1_empty", {63'h0, empty}, 64'h1);
      tick();

      // Fill to DEPTH with the bus stalled, then full and merge-into-full.
      for (int i = 0; i < 4; i++) begin
         store(64'(i * 8), 64'hA0A0_0000_0000_0000 | 64'(i), 8'h0F);
         tick();
      end
      idle(1'b0, 1'b0);
      check("s2_count_full", 64'(count), 64'd4);
      store(64'h20, 64'hDEAD, 8'hFF);
      check("s2_full_ready", {63'h0, st_ready}, 64'h0);
      tick();
      store(64'h18, 64'h5555_6666_0000_0000, 8'hF0);
      check("s2_merge_ready", {63'h0, st_ready}, 64'h1);
      tick();
      idle(1'b0, 1'b0);
      check("s2_count_after_merge", 64'(count), 64'd4);
      for (int k = 0; k < 4; k++) begin
         idle(1'b1, 1'b1);
         if (k == 3) begin
            check("s2_tail_addr", dreq_addr, 64'h18);
            check("s2_tail_strobe", {56'h0, dreq_strobe}, 64'hFF);
            check("s2_tail_data", dreq_data, 64'h5555_6666_0000_0003);
         end
         tick();
      end
      drain();

      // Merge behind a different head.
      store(64'h5000, 64'h0, 8'hFF);
      tick();
      store(64'h2000, 64'hDEAD_BEEF_AABB_CCDD, 8'h0F);
      tick();
      store(64'h2004, 64'h1122_3344_5566_7788, 8'hF0);
      tick();
      idle(1'b0, 1'b0);
      check("s3_count_merged", 64'(count), 64'd2);
      idle(1'b1, 1'b1);
      tick();
      idle(1'b1, 1'b1);
      check("s3_merged_strobe", {56'h0, dreq_strobe}, 64'hFF);
      check("s3_merged_data", dreq_data, 64'h1122_3344_AABB_CCDD);
      tick();
      drain();

      // Same doubleword with count==1 at the second store: no merge.
      store(64'h2000, 64'h0000_0000_AABB_CCDD, 8'h0F);
      tick();
      store(64'h2000, 64'h1122_3344_0000_0000, 8'hF0);
      tick();
      idle(1'b0, 1'b0);
      check("s3_no_merge_count", 64'(count), 64'd2);
      drain();

      // Split handshake: addr_ok at n, data_ok at n+3.
      store(64'h6000, 64'h6000, 8'hFF);
      tick();
      store(64'h6008, 64'h6008, 8'hFF);
      tick();
      idle(1'b1, 1'b0);
      check("s4_req_n", {63'h0, dreq_valid}, 64'h1);
      tick();
      for (int k = 1; k <= 3; k++) begin
         idle(1'($urandom_range(0, 1)), k == 3);
         check("s4_wait_valid", {63'h0, dreq_valid}, 64'h0);
         check("s4_wait_addr", dreq_addr, 64'h6000);
         check("s4_wait_count", 64'(count), 64'd2);
         tick();
      end
      idle(1'b0, 1'b0);
      check("s4_next_valid", {63'h0, dreq_valid}, 64'h1);
      check("s4_next_addr", dreq_addr, 64'h6008);
      check("s4_next_count", 64'(count), 64'd1);
      drain();

      // Load hazard against a pending entry.
      store(64'h3008, 64'h1, 8'h01);
      tick();
      set_in(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h300C, 1'b0, 1'b0);
      check("s5_stall_hit", {63'h0, ld_stall}, 64'h1);
      tick();
      set_in(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h3010, 1'b0, 1'b0);
      check("s5_stall_miss", {63'h0, ld_stall}, 64'h0);
      tick();
      drain();
      set_in(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 64'h300C, 1'b0, 1'b0);
      check("s5_stall_after_drain", {63'h0, ld_stall}, 64'h0);
      tick();

      // Asynchronous reset while a write is outstanding.
      for (int i = 0; i < 3; i++) begin
         store(64'h7000 + 64'(i * 8), 64'(i), 8'hFF);
         tick();
      end
      idle(1'b1, 1'b0);
      tick();
      idle(1'b0, 1'b0);
      check("s6_pre_wait_valid", {63'h0, dreq_valid}, 64'h0);
      check("s6_pre_count", 64'(count), 64'd3);
      reset = 1'b1;
      #1;
      check("s6_rst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
      check("s6_rst_count", 64'(count), 64'h0);
      check("s6_rst_empty", {63'h0, empty}, 64'h1);
      m_q.delete();
      m_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      set_in(1'b1, 64'h8000, 64'h8, 8'h80, 1'b0, 64'h0, 1'b1, 1'b1);
      tick();
      idle(1'b1, 1'b1);
      check("s6_resume_valid", {63'h0, dreq_valid}, 64'h1);
      check("s6_resume_addr", dreq_addr, 64'h8000);
      tick();
      drain();

      // Randomized traffic over a small address pool to provoke merges/hazards.
      for (int c = 0; c < 3000; c++) begin
         set_in(1'($urandom_range(0, 1)),
                64'h4000 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7)),
                {$urandom, $urandom},
                8'($urandom_range(1, 255)),
                1'($urandom_range(0, 1)),
                64'h4000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 5);
         tick();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
